// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock with
// timeout and bounded retries, and holds the system reset until the lock is stable.
module pll_lock_ctrl #(
   parameter int unsigned RST_CYCLES   = 10,
   parameter int unsigned LOCK_TIMEOUT = 5000,
   parameter int unsigned LOCK_STABLE  = 64,
   parameter int unsigned MAX_RETRY    = 3,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             relock_req,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic             fail,
   output logic [CNT_W-1:0] loss_cnt
);

   localparam int unsigned MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MAX_C = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
   localparam int unsigned TW    = $clog2(MAX_C + 1);
   localparam int unsigned RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAIL
   } state_t;

   state_t           state, state_nxt;
   logic [TW-1:0]    cnt, cnt_nxt;
   logic [RW-1:0]    retry_cnt, retry_nxt;
   logic [CNT_W-1:0] loss_nxt;
   logic             sync_q, locked_s;

   // pll_locked is asynchronous to clk
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync_q   <= pll_locked;
         locked_s <= sync_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RESET_PLL;
         cnt       <= '0;
         retry_cnt <= '0;
         loss_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         retry_cnt <= retry_nxt;
         loss_cnt  <= loss_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry_cnt;
      loss_nxt  = loss_cnt;
      if (relock_req) begin
         // relock wins over timeout and loss of lock; no loss is counted
         state_nxt = S_RESET_PLL;
         cnt_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            S_RESET_PLL: begin
               if (cnt == TW'(RST_CYCLES - 1)) begin
                  state_nxt = S_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + TW'(1);
               end
            end
            S_WAIT_LOCK: begin
               if (locked_s) begin
                  // this edge is the first stable sample
                  state_nxt = (LOCK_STABLE <= 1) ? S_RUN : S_STABLE;
                  cnt_nxt   = TW'(1);
               end else if (cnt == TW'(LOCK_TIMEOUT - 1)) begin
                  cnt_nxt = '0;
                  if (retry_cnt == RW'(MAX_RETRY)) begin
                     state_nxt = S_FAIL;
                  end else begin
                     state_nxt = S_RESET_PLL;
                     retry_nxt = retry_cnt + RW'(1);
                  end
               end else begin
                  cnt_nxt = cnt + TW'(1);
               end
            end
            S_STABLE: begin
               if (!locked_s) begin
                  state_nxt = S_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else if (cnt == TW'(LOCK_STABLE - 1)) begin
                  state_nxt = S_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + TW'(1);
               end
            end
            S_RUN: begin
               if (!locked_s) begin
                  state_nxt = S_RESET_PLL;
                  cnt_nxt   = '0;
                  retry_nxt = '0;
                  if (loss_cnt != {CNT_W{1'b1}}) begin
                     loss_nxt = loss_cnt + CNT_W'(1);
                  end
               end
            end
            S_FAIL: begin
               state_nxt = S_FAIL;
            end
            default: begin
               state_nxt = S_RESET_PLL;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign pll_rst = (state == S_RESET_PLL);
   assign ready   = (state == S_RUN);
   assign sys_rst = (state != S_RUN);
   assign fail    = (state == S_FAIL);

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: lock, chatter, loss of lock, retries/FAIL,
// relock requests and mid-sequence reset, with hand-computed cycle timing.
module tb_pll_lock_ctrl;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [7:0] loss_cnt;

   int total;
   int bad;

   pll_lock_ctrl #(
      .RST_CYCLES  (4),
      .LOCK_TIMEOUT(16),
      .LOCK_STABLE (8),
      .MAX_RETRY   (2),
      .CNT_W       (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pll_locked(pll_locked),
      .relock_req(relock_req),
      .pll_rst   (pll_rst),
      .sys_rst   (sys_rst),
      .ready     (ready),
      .fail      (fail),
      .loss_cnt  (loss_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // advance n rising edges; inputs are driven and outputs sampled 1 ns after each edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
      chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
      chk({tag, "_ready"}, 32'(ready), 0);
      chk({tag, "_fail"}, 32'(fail), 0);
      chk({tag, "_loss"}, 32'(loss_cnt), 0);
   endtask

   // drop pll_locked for 3 cycles while in RUN, then relock
   task automatic loss_cycle(input int exp_loss);
      pll_locked = 1'b0;
      tick(2);
      chk("loss_ready_hold", 32'(ready), 1);
      tick(1);
      chk("loss_ready", 32'(ready), 0);
      chk("loss_sys_rst", 32'(sys_rst), 1);
      chk("loss_pll_rst", 32'(pll_rst), 1);
      chk("loss_cnt", 32'(loss_cnt), 32'(exp_loss));
      pll_locked = 1'b1;
      tick(3);
      chk("loss_pulse_hi", 32'(pll_rst), 1);
      tick(1);
      chk("loss_pulse_lo", 32'(pll_rst), 0);
      tick(7);
      chk("loss_relock_early", 32'(ready), 0);
      tick(1);
      chk("loss_relock", 32'(ready), 1);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      tick(2);
      chk_reset_vals("reset");

      // normal lock
      rst = 1'b0;
      tick(3);
      chk("lock_pulse_hi", 32'(pll_rst), 1);
      tick(1);
      chk("lock_pulse_lo", 32'(pll_rst), 0);
      chk("lock_sys_rst", 32'(sys_rst), 1);
      tick(6);
      pll_locked = 1'b1;
      tick(9);
      chk("lock_ready_early", 32'(ready), 0);
      tick(1);
      chk("lock_ready", 32'(ready), 1);
      chk("lock_sys_rst_lo", 32'(sys_rst), 0);
      chk("lock_fail", 32'(fail), 0);
      chk("lock_loss", 32'(loss_cnt), 0);

      // three separate losses of lock in RUN
      for (int i = 1; i <= 3; i++) begin
         loss_cycle(i);
      end

      // relock_req in the same cycle the FSM sees the loss
      pll_locked = 1'b0;
      tick(2);
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      chk("simul_pll_rst", 32'(pll_rst), 1);
      chk("simul_ready", 32'(ready), 0);
      chk("simul_loss", 32'(loss_cnt), 3);

      // chatter during STABLE: 5 high, 1 low, then steady
      tick(4);
      chk("chat_wait", 32'(pll_rst), 0);
      pll_locked = 1'b1;
      tick(5);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick(1);
         chk("chat_ready_lo", 32'(ready), 0);
         chk("chat_no_pulse", 32'(pll_rst), 0);
      end
      tick(1);
      chk("chat_ready", 32'(ready), 1);

      // rst mid-RUN
      rst = 1'b1;
      tick(1);
      chk_reset_vals("rst_run");

      // lock never comes: three attempts then sticky FAIL
      rst        = 1'b0;
      pll_locked = 1'b0;
      for (int e = 1; e < 60; e++) begin
         tick(1);
         chk("nolock_pll_rst", 32'(pll_rst), ((e % 20) < 4) ? 1 : 0);
         chk("nolock_fail_lo", 32'(fail), 0);
      end
      tick(1);
      chk("nolock_fail", 32'(fail), 1);
      chk("nolock_pll_rst_fail", 32'(pll_rst), 0);
      for (int i = 0; i < 100; i++) begin
         tick(1);
         chk("fail_sticky", 32'(fail), 1);
         chk("fail_ready", 32'(ready), 0);
      end

      // relock from FAIL; retry count must be cleared so one timeout only retries
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      chk("relock_fail_clr", 32'(fail), 0);
      chk("relock_pll_rst", 32'(pll_rst), 1);
      tick(20);
      chk("relock_retry_pulse", 32'(pll_rst), 1);
      chk("relock_retry_fail", 32'(fail), 0);
      pll_locked = 1'b1;
      tick(11);
      chk("relock_ready_early", 32'(ready), 0);
      tick(1);
      chk("relock_ready", 32'(ready), 1);
      chk("relock_loss", 32'(loss_cnt), 0);

      // relock_req in RUN, then rst mid-WAIT_LOCK
      relock_req = 1'b1;
      pll_locked = 1'b0;
      tick(1);
      relock_req = 1'b0;
      chk("run_relock_ready", 32'(ready), 0);
      chk("run_relock_pll_rst", 32'(pll_rst), 1);
      chk("run_relock_loss", 32'(loss_cnt), 0);
      tick(6);
      chk("wait_pll_rst", 32'(pll_rst), 0);
      rst = 1'b1;
      tick(1);
      chk_reset_vals("rst_wait");

      // relock_req during RESET_PLL restarts the pulse
      rst = 1'b0;
      tick(2);
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      tick(3);
      chk("restart_pulse_hi", 32'(pll_rst), 1);
      tick(1);
      chk("restart_pulse_lo", 32'(pll_rst), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
- Reset/lock sequencer that drives the PLL's `rst` input and monitors its `locked` output.
- Runs on the 50 MHz reference clock. It pulses PLL reset, waits for `locked` with a timeout and bounded retries, then requires `locked` to hold stable before releasing the system reset.
- Handles loss-of-lock and software relock requests at runtime, and reports a sticky failure when retries are exhausted.

Parameters:
- RST_CYCLES, 10: PLL reset pulse width in clk cycles (≥1).
- LOCK_TIMEOUT, 5000: cycles allowed in WAIT_LOCK before a retry (≥2).
- LOCK_STABLE, 64: consecutive synchronized-locked cycles required before RUN (≥1).
- MAX_RETRY, 3: retries after the first attempt before FAIL.
- CNT_W, 8: width of the loss-of-lock counter.

Ports:
- clk  input  1  reference clock (50 MHz), also the PLL `refclk`
- rst  input  1  synchronous reset, active-high
- pll_locked  input  1  PLL `locked`; asynchronous to clk
- relock_req  input  1  single-cycle request to re-run the full lock sequence
- pll_rst  output  1  drives PLL `rst`
- sys_rst  output  1  active-high system reset for logic clocked by the PLL outputs
- ready  output  1  PLL locked and stable
- fail  output  1  sticky: lock not achieved within MAX_RETRY+1 attempts
- loss_cnt  output  CNT_W  number of loss-of-lock events in RUN; saturates at all-ones

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Synchronizer: two-flop synchronizer on `pll_locked` produces `locked_s`. It is reset to 0.
- FSM states: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL. Outputs are decoded directly from the state register (Moore); there is no extra output stage.
  - pll_rst = (state == RESET_PLL)
  - ready = (state == RUN)
  - sys_rst = (state != RUN)
  - fail = (state == FAIL)
- Reset: state = RESET_PLL; cycle counter = 0; retry_cnt = 0; loss_cnt = 0; synchronizer flops = 0. Immediately after reset: pll_rst=1, sys_rst=1, ready=0, fail=0.
- RESET_PLL: pll_rst is held high for exactly RST_CYCLES edges after entry, then the FSM moves to WAIT_LOCK and the counter clears.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE with stable count = 1.
  - Else, if LOCK_TIMEOUT edges have elapsed:
    - retry_cnt == MAX_RETRY: go to FAIL.
    - otherwise: retry_cnt+1 and go to RESET_PLL.
- STABLE:
  - If locked_s=0, go back to WAIT_LOCK. The timeout counter restarts; retry_cnt is unchanged.
  - When LOCK_STABLE consecutive locked_s=1 samples have been taken (counting the WAIT_LOCK exit edge), go to RUN.
  - Net timing: ready rises after edge k+LOCK_STABLE+1, where k is the first edge that samples pll_locked=1.
- RUN:
  - If locked_s=0: loss_cnt+1 (saturating), retry_cnt=0, go to RESET_PLL.
  - sys_rst reasserts in the same cycle ready drops.
- FAIL: sticky; pll_rst=0. Exits only via rst, or via relock_req (which clears retry_cnt and goes to RESET_PLL).
- relock_req:
  - Any state: go to RESET_PLL, clear the counter and retry_cnt. In RESET_PLL this restarts the pulse.
  - Takes priority over lock loss and timeout in the same cycle; no loss is counted.
- loss_cnt is cleared only by rst.
- rst mid-sequence: immediate return to the reset values above; no partial state is kept.
- Glitches on pll_locked shorter than one clk period may be missed; this is accepted.

Test Plan:
Common settings: RST_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE=8, MAX_RETRY=2; the bench models pll_locked.
1. Normal lock: release rst; pll_locked rises 6 cycles after pll_rst falls, first sampled at edge k.
   - Expect: pll_rst high exactly 4 cycles; ready=1 and sys_rst=0 after edge k+9; fail=0; loss_cnt=0.
2. Lock never comes: pll_locked held 0.
   - Expect: three pll_rst pulses of 4 cycles each, 16-cycle gaps; fail=1 after edge 60 from rst release; stays 1 for 100 more cycles; ready=0.
3. Chatter during STABLE: locked high 5 cycles, low 1, then steady.
   - Expect: FSM returns to WAIT_LOCK with no pll_rst pulse; ready only after 8 uninterrupted locked_s samples.
4. Loss of lock in RUN: drop pll_locked for 3 cycles, three separate times.
   - Expect: each drop gives ready=0, sys_rst=1 and a new 4-cycle pll_rst pulse; loss_cnt = 1, 2, 3; relock succeeds each time.
5. relock_req in FAIL and in RUN, including the same cycle as a lock loss.
   - Expect: fail clears; a fresh sequence runs; loss_cnt does not increment on the simultaneous request.
6. rst asserted mid-WAIT_LOCK and mid-RUN.
   - Expect: next cycle pll_rst=1, sys_rst=1, ready=0, fail=0, loss_cnt=0.
